jt6295_cmdgen: RTL and testbench
================================

# jt6295_cmdgen

Host-side command transmitter for the JT6295 CPU write port. It accepts "play phrase" and "stop channels" requests through a valid/ready handshake and queues them in a small FIFO. Each request is serialised into one or two `wrn`/`din` write cycles that the JT6295 bus interface latches on the rising edge of `wrn`. It sits between a sequencer or test harness and the JT6295 core, replacing a CPU in standalone and verification setups.

## Interface
- `W_LOW`, 2: cycles `wrn` is held low per write (≥1).
- `W_GAP`, 2: cycles `wrn` is held high after the rising edge, with `din` frozen (≥1).
- `DEPTH`, 4: request FIFO entries (power of two, ≥2).
- `rst` input 1: reset. Asynchronous, active-high.
- `clk` input 1: the block's only clock.
- `req_valid` input 1: a request is presented.
- `req_ready` output 1: the FIFO can accept a request. Equals !full.
- `req_stop` input 1: 1 = stop command, 0 = start command.
- `req_phrase` input 7: phrase number (start only).
- `req_ch` input 4: channel one-hot/mask. For a start, the channel to start; for a stop, the channels to stop.
- `req_att` input 4: attenuation (start only).
- `wrn` output 1: write strobe, active low.
- `din` output 8: write data.
- `idle` output 1: FIFO empty and FSM in IDLE.

## Operation
- Push on `req_valid && req_ready`. The entry {stop, phrase, ch, att} is 16 bits. A push is refused when full, even if a pop happens in the same cycle.
- Byte encoding:
  - Start command, byte 1: `{1'b1, phrase}`.
  - Start command, byte 2: `{ch, att}`.
  - Stop command, single byte: `{1'b0, ch, 3'b000}`.
- FSM states: IDLE, SETUP, LOW, HOLD.
  - IDLE → SETUP when the FIFO is non-empty. The head entry is read and byte 1 is placed on `din`. `wrn` stays 1.
  - SETUP → LOW after 1 cycle. `wrn` goes to 0 and the counter loads `W_LOW-1`.
  - LOW → HOLD when the counter reaches 0. `wrn` goes to 1; this is the latching edge. The counter loads `W_GAP-1`.
  - HOLD → SETUP (byte 2) when the counter reaches 0, the entry is a start command, and byte 1 was just sent.
  - Otherwise HOLD → IDLE, and the FIFO pops on that transition.
- The two bytes of a start command are atomic: no other entry is issued between them, and the entry is popped only after byte 2.
- `din` changes only on entry to SETUP. It is stable from SETUP through the end of HOLD.
- The counter width is clog2(max(`W_LOW`,`W_GAP`)+1).
- FIFO pointers are log2(`DEPTH`)+1 bits and wrap modulo 2·`DEPTH`. Full = MSBs differ and the low bits are equal.
- Simultaneous push and pop on a non-full FIFO: both take effect and the count is unchanged.
- Push into an empty FIFO while the FSM is in IDLE: the entry is visible next cycle.

## Timing
- Reset values: `wrn`=1, `din`=0x00, `req_ready`=1, `idle`=1. The FIFO is empty and the FSM is in IDLE.
- Reset asserted mid-write: `wrn` returns to 1 immediately and all queued requests are discarded. Because the write is aborted without a rising edge, the JT6295 may be left expecting a second byte. The controller owning reset is responsible for resetting both blocks together.
- Push accepted at edge N, FIFO empty, FSM idle:
  - SETUP and `din` = byte 1 at edge N+1.
  - `wrn` falls at edge N+2.
  - `wrn` rises at edge N+2+`W_LOW`.
- Cycles per write: 1+`W_LOW`+`W_GAP`. A stop command takes one write; a start command takes two.
- Back-to-back entries: the next SETUP begins in the cycle after HOLD ends (the IDLE cycle is included). The minimum spacing between rising edges of `wrn` across entries is 2+`W_LOW`+`W_GAP`.
- `idle` is registered and deasserts the cycle after the first push.

## Structure
- Shared header `jt6295_defs.vh` holds the command-byte constants (start flag bit 7, stop-mask field [6:3]). The JT6295 core's bus interface uses the same header.
- FIFO is a separate sub-module, `jt6295_cmdfifo` (parameter `DEPTH`, 16-bit data, push/pop/full/empty).
- FSM, counter and byte mux live in `jt6295_cmdgen`.

## Test plan
- Reset, then start with phrase 0x05, ch 4'b0010, att 3, defaults → `din` 0x85 latched at the first `wrn` rise, then 0x23. The rise-to-rise spacing is 5 cycles. `idle` returns to 1.
- Stop with mask 4'b1001 → exactly one write of 0x48. `wrn` is low for 2 cycles. The FIFO pops after HOLD.
- Push 5 starts with `DEPTH`=4 while the FSM is busy → `req_ready` drops after the 4th accepted push. The 5th is held until a pop, and all 5 pairs are issued in order.
- `W_LOW`=1, `W_GAP`=3, a stop followed by a start → write count 3. `din` is stable during every HOLD, and no byte is issued between 0x85 and the second byte.
- Assert `rst` while `wrn`=0 during byte 1 → `wrn`=1 asynchronously, `din`=0x00, the FIFO is empty. The next request after release is issued normally.
- Connect to the JT6295 core and issue a start → the core asserts `start` for ch 2 with the expected `start_addr` from the ROM table.

Source files
------------

// File: rtl/jt6295_cmdgen_pkg.sv
// Shared definitions for the JT6295 host-side command transmitter.
// Holds the FSM state type, the queued request layout and the
// command-byte encoding helpers shared with the core's bus interface.
package jt6295_cmdgen_pkg;

    // Bit positions inside a command byte
    localparam int START_FLAG_BIT = 7;   // byte 1 of a start command
    localparam int STOP_MASK_LSB  = 3;   // stop mask occupies [6:3]

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_LOW   = 2'd2,
        ST_HOLD  = 2'd3
    } cmd_state_t;

    // One queued request, 16 bits total
    typedef struct packed {
        logic       stop;
        logic [6:0] phrase;
        logic [3:0] ch;
        logic [3:0] att;
    } cmd_req_t;

    // First (or only) byte written for a request
    function automatic logic [7:0] first_byte(input cmd_req_t r);
        logic [7:0] b;
        b = '0;
        if (r.stop) begin
            b[STOP_MASK_LSB +: 4] = r.ch;
        end else begin
            b[START_FLAG_BIT] = 1'b1;
            b[6:0]            = r.phrase;
        end
        return b;
    endfunction

    // Second byte of a start command
    function automatic logic [7:0] second_byte(input cmd_req_t r);
        return {r.ch, r.att};
    endfunction

endpackage

// File: rtl/jt6295_cmdfifo.sv
// Request FIFO for jt6295_cmdgen.
// Ports: clk, rst (async, active-high), push/wdata write side,
// pop/rdata read side (rdata shows the head entry combinationally),
// full, empty, level (entry count).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module jt6295_cmdfifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [15:0]                wdata,
    input  logic                       pop,
    output logic [15:0]                rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: it is only read while the FIFO is non-empty
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/jt6295_cmdgen.sv
// Host-side command transmitter for the JT6295 CPU write port.
// Ports: clk, rst (async, active-high); request side req_valid/req_ready
// with req_stop, req_phrase, req_ch, req_att; bus side wrn (active-low
// strobe, data latched by the core on its rising edge) and din;
// idle (FIFO empty and FSM idle); dbg_state (current FSM state).
// Handshake: a request is taken on any clock edge where req_valid and
// req_ready are both high; req_ready is simply "FIFO not full" and does
// not look at a pop happening in the same cycle.
module jt6295_cmdgen
    import jt6295_cmdgen_pkg::*;
#(
    parameter int W_LOW = 2,
    parameter int W_GAP = 2,
    parameter int DEPTH = 4
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_stop,
    input  logic [6:0] req_phrase,
    input  logic [3:0] req_ch,
    input  logic [3:0] req_att,
    output logic       wrn,
    output logic [7:0] din,
    output logic       idle,
    output logic [1:0] dbg_state
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int WMAX = (W_LOW > W_GAP) ? W_LOW : W_GAP;
    localparam int CW   = $clog2(WMAX + 1);

    cmd_state_t  state;
    logic [CW-1:0] cnt;
    logic        second;      // byte 2 of a start command is the one on the bus
    cmd_req_t    req_in;
    cmd_req_t    head;
    logic [15:0] head_raw;
    logic        full;
    logic        empty;
    logic [LW-1:0] level;
    logic [LW-1:0] level_next;
    logic        push;
    logic        pop;
    logic        going_idle;

    assign req_in    = {req_stop, req_phrase, req_ch, req_att};
    assign head      = cmd_req_t'(head_raw);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    // The entry leaves the FIFO only once its last byte has finished HOLD
    assign pop       = (state == ST_HOLD) && (cnt == '0) && (head.stop || second);
    assign dbg_state = state;

    // idle is registered, so it is computed from what the FIFO and FSM
    // will look like after this edge
    assign going_idle = ((state == ST_IDLE) && empty) || pop;
    assign level_next = level + LW'(push) - LW'(pop);

    jt6295_cmdfifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (req_in),
        .pop   (pop),
        .rdata (head_raw),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            second <= 1'b0;
            wrn    <= 1'b1;
            din    <= 8'h00;
            idle   <= 1'b1;
        end else begin
            idle <= going_idle && (level_next == '0);
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        state  <= ST_SETUP;
                        din    <= first_byte(head);
                        second <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    state <= ST_LOW;
                    wrn   <= 1'b0;
                    cnt   <= CW'(W_LOW - 1);
                end
                ST_LOW: begin
                    if (cnt == '0) begin
                        state <= ST_HOLD;
                        wrn   <= 1'b1;
                        cnt   <= CW'(W_GAP - 1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        // Byte 2 follows directly so a start pair is never split
                        if (!head.stop && !second) begin
                            state  <= ST_SETUP;
                            din    <= second_byte(head);
                            second <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jt6295_cmdgen.sv
// Self-checking bench for jt6295_cmdgen: one instance with default
// write timing, one with W_LOW=1 / W_GAP=3.
module tb_jt6295_cmdgen;

    localparam int WL_A = 2;
    localparam int WG_A = 2;
    localparam int WL_B = 1;
    localparam int WG_B = 3;
    localparam int BOUND = 300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A
    logic       a_rst = 1'b1, a_valid = 1'b0, a_stop = 1'b0;
    logic [6:0] a_phrase = '0;
    logic [3:0] a_ch = '0, a_att = '0;
    logic       a_ready, a_wrn, a_idle;
    logic [7:0] a_din;
    logic [1:0] a_state;
    // DUT B
    logic       b_rst = 1'b1, b_valid = 1'b0, b_stop = 1'b0;
    logic [6:0] b_phrase = '0;
    logic [3:0] b_ch = '0, b_att = '0;
    logic       b_ready, b_wrn, b_idle;
    logic [7:0] b_din;
    logic [1:0] b_state;

    jt6295_cmdgen #(.W_LOW(WL_A), .W_GAP(WG_A), .DEPTH(4)) dut_a (
        .rst(a_rst), .clk(clk), .req_valid(a_valid), .req_ready(a_ready),
        .req_stop(a_stop), .req_phrase(a_phrase), .req_ch(a_ch), .req_att(a_att),
        .wrn(a_wrn), .din(a_din), .idle(a_idle), .dbg_state(a_state)
    );

    jt6295_cmdgen #(.W_LOW(WL_B), .W_GAP(WG_B), .DEPTH(4)) dut_b (
        .rst(b_rst), .clk(clk), .req_valid(b_valid), .req_ready(b_ready),
        .req_stop(b_stop), .req_phrase(b_phrase), .req_ch(b_ch), .req_att(b_att),
        .wrn(b_wrn), .din(b_din), .idle(b_idle), .dbg_state(b_state)
    );

    // Scoreboard: expected bytes per DUT, bit 8 marks the second byte of a start
    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, expv, cyc);
        end
    endtask

    // Bus monitor: every rising edge of wrn is one latched byte
    logic       prev_w[2];
    int         low_n[2];
    int         hold_n[2];
    logic [7:0] hold_b[2];
    logic [7:0] low_b[2];
    int         last_rise[2];
    int         writes[2] = '{0, 0};
    logic       m_w, m_r, m_have;
    logic [7:0] m_d;
    logic [8:0] m_e;
    int         m_wl, m_wg, m_gap;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_w  = (k == 0) ? a_wrn : b_wrn;
            m_d  = (k == 0) ? a_din : b_din;
            m_r  = (k == 0) ? a_rst : b_rst;
            m_wl = (k == 0) ? WL_A : WL_B;
            m_wg = (k == 0) ? WG_A : WG_B;
            if (m_r) begin
                prev_w[k]    = 1'b1;
                low_n[k]     = 0;
                hold_n[k]    = 0;
                last_rise[k] = -1000;
            end else begin
                if (!m_w) begin
                    if (low_n[k] == 0) low_b[k] = m_d;
                    else check("din_stable_low", m_d, low_b[k]);
                    if (hold_n[k] > 0) begin
                        check("gap_too_short", hold_n[k], 0);
                        hold_n[k] = 0;
                    end
                    low_n[k]++;
                end else if (!prev_w[k]) begin
                    check("wrn_low_len", low_n[k], m_wl);
                    low_n[k] = 0;
                    m_have = 1'b0;
                    if (k == 0 && exp_a.size() > 0) begin m_e = exp_a.pop_front(); m_have = 1'b1; end
                    if (k == 1 && exp_b.size() > 0) begin m_e = exp_b.pop_front(); m_have = 1'b1; end
                    check("write_expected", m_have, 1'b1);
                    if (m_have) begin
                        check("byte", m_d, m_e[7:0]);
                        m_gap = cyc - last_rise[k];
                        if (m_e[8]) check("pair_spacing", m_gap, 1 + m_wl + m_wg);
                        else check("entry_spacing_ok", m_gap >= 2 + m_wl + m_wg, 1'b1);
                    end
                    last_rise[k] = cyc;
                    hold_n[k]    = m_wg - 1;
                    hold_b[k]    = m_d;
                    writes[k]++;
                end else if (hold_n[k] > 0) begin
                    check("din_stable_hold", m_d, hold_b[k]);
                    hold_n[k]--;
                end
                prev_w[k] = m_w;
            end
        end
    end

    // Driver: present one request, wait for acceptance, record expected bytes
    task automatic push_req(input int k, input logic stop, input logic [6:0] ph,
                            input logic [3:0] ch, input logic [3:0] att, output int waited);
        logic [8:0] e1, e2;
        @(negedge clk);
        if (k == 0) begin a_stop = stop; a_phrase = ph; a_ch = ch; a_att = att; a_valid = 1'b1; end
        else        begin b_stop = stop; b_phrase = ph; b_ch = ch; b_att = att; b_valid = 1'b1; end
        waited = 0;
        while (((k == 0) ? !a_ready : !b_ready) && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= BOUND) begin
            check("push_timeout", waited, 0);
            a_valid = 1'b0;
            b_valid = 1'b0;
            return;
        end
        if (stop) begin
            e1 = {1'b0, 8'(ch * 8)};
            if (k == 0) exp_a.push_back(e1); else exp_b.push_back(e1);
        end else begin
            e1 = {1'b0, 8'(128 + ph)};
            e2 = {1'b1, 8'(ch * 16 + att)};
            if (k == 0) begin exp_a.push_back(e1); exp_a.push_back(e2); end
            else        begin exp_b.push_back(e1); exp_b.push_back(e2); end
        end
        @(posedge clk);
        #1;
        if (k == 0) a_valid = 1'b0; else b_valid = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (n < BOUND && !((k == 0) ? (a_idle && exp_a.size() == 0)
                                       : (b_idle && exp_b.size() == 0))) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", n < BOUND, 1'b1);
        check("exp_left", (k == 0) ? exp_a.size() : exp_b.size(), 0);
    endtask

    int w, w0, n;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_a_wrn", a_wrn, 1'b1);
        check("rst_a_din", a_din, 8'h00);
        check("rst_a_ready", a_ready, 1'b1);
        check("rst_a_idle", a_idle, 1'b1);
        check("rst_b_wrn", b_wrn, 1'b1);
        check("rst_b_din", b_din, 8'h00);
        check("rst_b_ready", b_ready, 1'b1);
        check("rst_b_idle", b_idle, 1'b1);
        a_rst = 1'b0;
        b_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Start phrase 5, ch 2, att 3: exact latency from the accepting edge N
        w0 = writes[0];
        push_req(0, 1'b0, 7'h05, 4'b0010, 4'd3, w);
        @(negedge clk);  // after N
        check("t1_idle_low", a_idle, 1'b0);
        check("t1_wrn_n", a_wrn, 1'b1);
        @(negedge clk);  // after N+1
        check("t1_din_setup", a_din, 8'h85);
        check("t1_wrn_setup", a_wrn, 1'b1);
        @(negedge clk);  // after N+2
        check("t1_wrn_fall", a_wrn, 1'b0);
        @(negedge clk);  // after N+3
        check("t1_wrn_low2", a_wrn, 1'b0);
        @(negedge clk);  // after N+4
        check("t1_wrn_rise", a_wrn, 1'b1);
        check("t1_din_rise", a_din, 8'h85);
        wait_idle(0);
        check("t1_idle_back", a_idle, 1'b1);
        check("t1_writes", writes[0] - w0, 2);

        // Stop mask 1001: one write of 0x48
        w0 = writes[0];
        push_req(0, 1'b1, 7'h00, 4'b1001, 4'd0, w);
        wait_idle(0);
        check("t2_writes", writes[0] - w0, 1);

        // Five starts while busy: FIFO of 4 fills, fifth waits for a pop
        w0 = writes[0];
        for (int i = 0; i < 5; i++) begin
            push_req(0, 1'b0, 7'($urandom_range(0, 127)), 4'(1 << (i % 4)),
                     4'($urandom_range(0, 15)), w);
            if (i < 4) check("t3_no_wait", w, 0);
            if (i == 3) check("t3_ready_full", a_ready, 1'b0);
            if (i == 4) check("t3_fifth_waited", w > 0, 1'b1);
        end
        wait_idle(0);
        check("t3_writes", writes[0] - w0, 10);

        // W_LOW=1, W_GAP=3: stop then start is three writes
        w0 = writes[1];
        push_req(1, 1'b1, 7'h00, 4'b0100, 4'd0, w);
        push_req(1, 1'b0, 7'h05, 4'b0001, 4'd7, w);
        wait_idle(1);
        check("t4_writes", writes[1] - w0, 3);

        // Reset during byte 1 with more requests queued behind it
        push_req(0, 1'b0, 7'h11, 4'b0100, 4'd1, w);
        push_req(0, 1'b1, 7'h00, 4'b1111, 4'd0, w);
        push_req(0, 1'b0, 7'h22, 4'b1000, 4'd2, w);
        n = 0;
        while (a_wrn && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_wrn_low_seen", a_wrn, 1'b0);
        #2;
        a_rst = 1'b1;
        exp_a.delete();
        #1;
        check("t5_wrn_async", a_wrn, 1'b1);
        check("t5_din_clr", a_din, 8'h00);
        check("t5_ready", a_ready, 1'b1);
        check("t5_idle", a_idle, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_still_quiet", a_wrn, 1'b1);
        w0 = writes[0];
        push_req(0, 1'b1, 7'h00, 4'b0011, 4'd0, w);
        wait_idle(0);
        check("t5_writes", writes[0] - w0, 1);

        // Random traffic on both instances
        for (int i = 0; i < 40; i++) begin
            push_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), w);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(0);
        wait_idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
